// File: rtl/eth_latency_pkg.sv
// Shared types and widths for the Ethernet latency sweep controller.
package eth_latency_pkg;

    localparam int unsigned PSIZE_W = 16;
    localparam int unsigned TIME_W  = 32;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned RTT_W   = 33;
    localparam int unsigned SUM_W   = 64;

    localparam logic [TIME_W-1:0] LOST_TIME = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StReport,
        StFinish
    } sweep_state_e;

endpackage

// File: rtl/eth_latency_stats_acc.sv
// Per-step round statistics: lost counters, round counter and RTT min/max/sum.
module eth_latency_stats_acc
    import eth_latency_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              update,
    input  logic [TIME_W-1:0] ping_time,
    input  logic [TIME_W-1:0] pong_time,
    output logic [CNT_W-1:0]  rounds,
    output logic [CNT_W-1:0]  pings_lost,
    output logic [CNT_W-1:0]  pongs_lost,
    output logic [RTT_W-1:0]  rtt_min,
    output logic [RTT_W-1:0]  rtt_max,
    output logic [SUM_W-1:0]  rtt_sum
);

    logic [CNT_W-1:0] rounds_q, pings_lost_q, pongs_lost_q;
    logic [RTT_W-1:0] rtt_min_q, rtt_max_q, rtt;
    logic [SUM_W-1:0] rtt_sum_q;

    // Full 33-bit sum so two near-max 32-bit times never truncate.
    assign rtt = {1'b0, ping_time} + {1'b0, pong_time};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rounds_q     <= '0;
            pings_lost_q <= '0;
            pongs_lost_q <= '0;
            rtt_min_q    <= '1;
            rtt_max_q    <= '0;
            rtt_sum_q    <= '0;
        end else if (update) begin
            rounds_q <= rounds_q + 32'd1;
            if (ping_time == LOST_TIME) begin
                pings_lost_q <= pings_lost_q + 32'd1;
            end else if (pong_time == LOST_TIME) begin
                pongs_lost_q <= pongs_lost_q + 32'd1;
            end else begin
                if (rtt < rtt_min_q) rtt_min_q <= rtt;
                if (rtt > rtt_max_q) rtt_max_q <= rtt;
                rtt_sum_q <= rtt_sum_q + {{(SUM_W-RTT_W){1'b0}}, rtt};
            end
        end
    end

    assign rounds     = rounds_q;
    assign pings_lost = pings_lost_q;
    assign pongs_lost = pongs_lost_q;
    assign rtt_min    = rtt_min_q;
    assign rtt_max    = rtt_max_q;
    assign rtt_sum    = rtt_sum_q;

endmodule

// File: rtl/eth_latency_sweep_ctrl.sv
// Steps a latency coordinator through a packet-size sweep and reports per-size statistics.
module eth_latency_sweep_ctrl
    import eth_latency_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [PSIZE_W-1:0] psize_min,
    input  logic [PSIZE_W-1:0] psize_max,
    input  logic [PSIZE_W-1:0] psize_step,
    input  logic [CNT_W-1:0]   pings_per_step,
    output logic               coord_enable,
    output logic [PSIZE_W-1:0] coord_psize,
    input  logic               coord_done,
    input  logic [TIME_W-1:0]  coord_ping_time,
    input  logic [TIME_W-1:0]  coord_pong_time,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [PSIZE_W-1:0] res_psize,
    output logic [CNT_W-1:0]   res_rounds,
    output logic [CNT_W-1:0]   res_pings_lost,
    output logic [CNT_W-1:0]   res_pongs_lost,
    output logic [RTT_W-1:0]   res_rtt_min,
    output logic [RTT_W-1:0]   res_rtt_max,
    output logic [SUM_W-1:0]   res_rtt_sum,
    output logic               busy,
    output logic               sweep_done
);

    sweep_state_e       state_q, state_d;
    logic [PSIZE_W-1:0] psize_q, psize_d, max_q, step_q;
    logic [CNT_W-1:0]   pings_q;
    logic               stop_q, stop_d;
    logic               cfg_load, stats_clear, stats_update;
    logic [PSIZE_W:0]   next_psize;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            psize_q <= '0;
            max_q   <= '0;
            step_q  <= '0;
            pings_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            psize_q <= psize_d;
            stop_q  <= stop_d;
            if (cfg_load) begin
                max_q   <= psize_max;
                step_q  <= psize_step;
                pings_q <= (pings_per_step == '0) ? 32'd1 : pings_per_step;
            end
        end
    end

    // Widened so a step past 16'hFFFF ends the sweep instead of wrapping.
    assign next_psize = {1'b0, psize_q} + {1'b0, step_q};

    always_comb begin
        state_d      = state_q;
        psize_d      = psize_q;
        stop_d       = stop_q;
        cfg_load     = 1'b0;
        stats_clear  = 1'b0;
        stats_update = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cfg_load    = 1'b1;
                    psize_d     = psize_min;
                    stats_clear = 1'b1;
                    stop_d      = 1'b0;
                    state_d     = StRun;
                end
            end
            StRun: begin
                if (stop) stop_d = 1'b1;
                if (coord_done) begin
                    stats_update = 1'b1;
                    if ((res_rounds + 32'd1 == pings_q) || stop || stop_q) state_d = StReport;
                end
            end
            StReport: begin
                if (res_ready) begin
                    if ((step_q == '0) || (next_psize > {1'b0, max_q}) || stop_q) begin
                        state_d = StFinish;
                    end else begin
                        psize_d     = next_psize[PSIZE_W-1:0];
                        stats_clear = 1'b1;
                        state_d     = StRun;
                    end
                end
            end
            StFinish: begin
                stop_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    eth_latency_stats_acc u_stats (
        .clk        (clk),
        .rst        (rst),
        .clear      (stats_clear),
        .update     (stats_update),
        .ping_time  (coord_ping_time),
        .pong_time  (coord_pong_time),
        .rounds     (res_rounds),
        .pings_lost (res_pings_lost),
        .pongs_lost (res_pongs_lost),
        .rtt_min    (res_rtt_min),
        .rtt_max    (res_rtt_max),
        .rtt_sum    (res_rtt_sum)
    );

    assign coord_enable = (state_q == StRun);
    assign coord_psize  = psize_q;
    assign res_valid    = (state_q == StReport);
    assign res_psize    = psize_q;
    assign busy         = (state_q == StRun) || (state_q == StReport);
    assign sweep_done   = (state_q == StFinish);

endmodule

// File: doc/eth_latency_sweep_ctrl.md
ETH_LATENCY_SWEEP_CTRL -- requirements
Module: eth_latency_sweep_ctrl

Interface
REQ-001 SHALL have: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have: start  in  1  one-cycle pulse, begins sweep when idle; stop  in  1  one-cycle pulse, aborts sweep at end of current round.
REQ-003 SHALL have: psize_min, psize_max, psize_step  in  16 each  sweep range/step (bytes); pings_per_step  in  32  rounds per size.
REQ-004 SHALL have: coord_enable  out  1  run request to latency coordinator; coord_psize  out  16  size request to coordinator.
REQ-005 SHALL have: coord_done  in  1  one-cycle round-complete pulse; coord_ping_time, coord_pong_time  in  32 each  round times, all-ones = lost.
REQ-006 SHALL have: res_valid  out  1; res_ready  in  1; res_psize  out  16; res_rounds, res_pings_lost, res_pongs_lost  out  32 each; res_rtt_min, res_rtt_max  out  33 each; res_rtt_sum  out  64.
REQ-007 SHALL have: busy  out  1  high from accepted start until sweep end; sweep_done  out  1  one-cycle pulse at sweep end.

Function
REQ-008 SHALL implement states IDLE, RUN, REPORT, FINISH.
REQ-009 IDLE: start latches psize_min/max/step and pings_per_step (0 treated as 1), sets coord_psize=psize_min, clears stats, -> RUN next cycle; start while not IDLE SHALL be ignored.
REQ-010 RUN: coord_enable=1; each coord_done increments round counter and updates stats the following cycle.
REQ-011 Round classification: ping_time all-ones -> pings_lost+1; else pong_time all-ones -> pongs_lost+1; else rtt = ping_time+pong_time (33-bit, no truncation) into min/max/sum.
REQ-012 rtt_sum SHALL be 64-bit wrapping; min initialised all-ones (33 bits), max 0; step with zero successful rounds reports min all-ones, max 0, sum 0.
REQ-013 On coord_done completing round count == pings_per_step, coord_enable SHALL be low from the next clock edge, and state -> REPORT.
REQ-014 stop pulse in RUN SHALL set a pending flag; next coord_done -> REPORT with partial counts; after acceptance -> FINISH (no further steps). stop outside RUN SHALL be ignored.
REQ-015 REPORT: res_valid=1, all res_* stable until res_ready sampled high; coord_enable stays 0; transfer occurs in cycle with res_valid&res_ready.
REQ-016 After transfer: next = psize+step computed 17-bit; if step==0, or next>psize_max, or stop pending -> FINISH; else coord_psize=next, stats cleared, -> RUN next cycle.
REQ-017 coord_psize SHALL change only while coord_enable is 0.
REQ-018 psize_min>psize_max: exactly one step at psize_min SHALL run, then FINISH.
REQ-019 FINISH: sweep_done pulses one cycle, busy drops, -> IDLE.
REQ-020 coord_done received outside RUN SHALL be ignored.
REQ-021 Latency: start to coord_enable high = 1 cycle; final coord_done to res_valid high = 1 cycle; transfer to coord_enable high = 1 cycle.

Reset
REQ-022 rst SHALL force IDLE; coord_enable, busy, res_valid, sweep_done = 0; coord_psize, res_psize, counters, sum, max = 0; min = all-ones; stop flag cleared.
REQ-023 rst mid-sweep SHALL drop coord_enable the following edge and discard partial stats; no res_valid emitted.

Structure
REQ-024 Package eth_latency_pkg SHALL hold state enum, RTT_W=33, SUM_W=64, LOST_TIME=32'hFFFFFFFF.
REQ-025 Sub-module eth_latency_stats_acc SHALL hold classification, min/max/sum and lost/round counters with clear and update inputs.

Verification
REQ-026 min=64,max=128,step=32,pings=2, all times 100/50 -> 3 reports, psize 64/96/128, rounds 2, rtt min=max=150, sum 300, then sweep_done.
REQ-027 pings=3, rounds (ping,pong) = (all-ones,x),(10,all-ones),(20,30) -> pings_lost 1, pongs_lost 1, min=max=sum=50.
REQ-028 res_ready held low 20 cycles -> res_* stable, coord_enable 0 throughout, next step starts 1 cycle after ready.
REQ-029 stop during round 2 of pings=5 -> report rounds 2 after that done, then sweep_done, no further coord_enable.
REQ-030 max=65535, min=65500, step=100 -> single step, no 16-bit wrap; step=0 -> single step.
REQ-031 rst asserted in RUN -> coord_enable 0 next edge, all outputs at reset values, later start runs cleanly.
